// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the dmem_pipe data-memory block.
//   - mask_mode_e : access size encoding on the request side
//   - resp_err_e  : error codes reported with each response
//   - state_e     : request FSM state encoding
//   - classify_req: request error classification, highest priority first
package dmem_pkg;

  typedef enum logic [1:0] {
    MM_BYTE    = 2'b00,
    MM_HALF    = 2'b01,
    MM_WORD    = 2'b10,
    MM_ILLEGAL = 2'b11
  } mask_mode_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } resp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Illegal command beats misalignment, which beats out-of-range.
  function automatic logic [1:0] classify_req(
    input logic        rd,
    input logic        wr,
    input logic [1:0]  mm,
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    if ((rd == wr) || (mm == MM_ILLEGAL)) begin
      return ERR_ILLEGAL;
    end else if (((mm == MM_HALF) && addr[0]) ||
                 ((mm == MM_WORD) && (addr[1:0] != 2'b00))) begin
      return ERR_MISALIGN;
    end else if (word_idx >= depth) begin
      return ERR_RANGE;
    end else begin
      return ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for dmem_pipe.
// Ports:
//   mask_mode  in  2   access size (byte/half/word)
//   byte_off   in  2   addr[1:0] of the access
//   sext       in  1   sign-extend byte/half loads
//   wdata      in  32  right-aligned store data
//   rword      in  32  memory word at the addressed index
//   load_data  out 32  extracted, extended load result
//   byte_en    out 4   store byte-lane enables
//   store_data out 32  store data replicated onto every lane
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  mask_mode,
  input  logic [1:0]  byte_off,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data
);

  logic [31:0] shifted_s;

  // Bring the addressed lane down to bit 0 so extraction is lane-independent.
  assign shifted_s = rword >> {byte_off, 3'b000};

  // Load extension and store lane-enable generation by access size.
  always_comb begin
    load_data  = 32'h0000_0000;
    byte_en    = 4'b0000;
    store_data = 32'h0000_0000;
    case (mask_mode_e'(mask_mode))
      MM_BYTE: begin
        load_data  = sext ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                          : {24'h00_0000, shifted_s[7:0]};
        byte_en    = 4'b0001 << byte_off;
        store_data = {4{wdata[7:0]}};
      end
      MM_HALF: begin
        load_data  = sext ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                          : {16'h0000, shifted_s[15:0]};
        byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      MM_WORD: begin
        load_data  = rword;
        byte_en    = 4'b1111;
        store_data = wdata;
      end
      default: begin
        load_data  = 32'h0000_0000;
        byte_en    = 4'b0000;
        store_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: single-outstanding data memory with fixed response latency.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready, addr, wdata, mem_read, mem_write, mask_mode, sext
//   resp_valid/resp_ready, resp_good, resp_err, rdata
// A request is accepted in IDLE, waits LATENCY-1 cycles in WAIT, then is
// held in RESP until the consumer takes it. Stores commit and loads sample
// memory on the edge that enters RESP.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mask_mode,
  input  logic        sext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_good,
  output logic [1:0]  resp_err,
  output logic [31:0] rdata
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        rd_q, rd_d, wr_q, wr_d, sext_q, sext_d;
  logic [1:0]  mm_q, mm_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d, resp_good_q, resp_good_d;
  logic [1:0]  resp_err_q, resp_err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH];

  logic        accept_s, to_resp_s, commit_s;
  logic [31:0] cur_addr_s, cur_wdata_s;
  logic        cur_rd_s, cur_wr_s, cur_sext_s;
  logic [1:0]  cur_mm_s, cur_err_s;
  logic [AW-1:0] cur_idx_s;
  logic [31:0] rword_s, load_data_s, store_data_s;
  logic [3:0]  byte_en_s;

  assign accept_s = req_valid & req_ready_q & (state_q == ST_IDLE);

  // The live request: raw inputs on the accept cycle (needed when LATENCY=1), latched copy afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr_s  = addr;
      cur_wdata_s = wdata;
      cur_rd_s    = mem_read;
      cur_wr_s    = mem_write;
      cur_mm_s    = mask_mode;
      cur_sext_s  = sext;
    end else begin
      cur_addr_s  = addr_q;
      cur_wdata_s = wdata_q;
      cur_rd_s    = rd_q;
      cur_wr_s    = wr_q;
      cur_mm_s    = mm_q;
      cur_sext_s  = sext_q;
    end
  end

  assign cur_err_s = classify_req(cur_rd_s, cur_wr_s, cur_mm_s, cur_addr_s, DEPTH_W);
  assign cur_idx_s = cur_addr_s[AW+1:2];
  assign rword_s   = mem_q[cur_idx_s];

  dmem_lane_align u_lane_align (
    .mask_mode  (cur_mm_s),
    .byte_off   (cur_addr_s[1:0]),
    .sext       (cur_sext_s),
    .wdata      (cur_wdata_s),
    .rword      (rword_s),
    .load_data  (load_data_s),
    .byte_en    (byte_en_s),
    .store_data (store_data_s)
  );

  // Next-state, latch and response-register logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    mm_d         = mm_q;
    sext_d       = sext_q;
    resp_valid_d = resp_valid_q;
    resp_good_d  = resp_good_q;
    resp_err_d   = resp_err_q;
    rdata_d      = rdata_q;
    to_resp_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d  = addr;
          wdata_d = wdata;
          rd_d    = mem_read;
          wr_d    = mem_write;
          mm_d    = mask_mode;
          sext_d  = sext;
          if (LATENCY == 1) begin
            to_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Leave when this decrement reaches zero.
        if (cnt_q <= 4'd1) begin
          to_resp_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_good_d  = 1'b0;
          resp_err_d   = ERR_NONE;
          rdata_d      = 32'h0000_0000;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (to_resp_s) begin
      state_d      = ST_RESP;
      cnt_d        = 4'd0;
      resp_valid_d = 1'b1;
      resp_good_d  = (cur_err_s == ERR_NONE);
      resp_err_d   = cur_err_s;
      rdata_d      = (cur_rd_s && (cur_err_s == ERR_NONE)) ? load_data_s : 32'h0000_0000;
    end else begin
      rdata_d = rdata_d;
    end
    req_ready_d = (state_d == ST_IDLE);
  end

  assign commit_s = to_resp_s & cur_wr_s & (cur_err_s == ERR_NONE);

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      mm_q         <= 2'b00;
      sext_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_good_q  <= 1'b0;
      resp_err_q   <= ERR_NONE;
      rdata_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      mm_q         <= mm_d;
      sext_q       <= sext_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_good_q  <= resp_good_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Memory array: never cleared; a reset edge drops a pending store.
  always_ff @(posedge clk) begin
    if (reset && commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_q[cur_idx_s][8*i +: 8] <= store_data_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_good  = resp_good_q;
  assign resp_err   = resp_err_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: randomized and directed self-checking bench for dmem_pipe.
// A word-array reference model predicts each response from plain arithmetic.
module tb_dmem_pipe;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] addr, wdata;
  logic        mem_read, mem_write;
  logic [1:0]  mask_mode;
  logic        sext;
  logic        resp_valid, resp_ready, resp_good;
  logic [1:0]  resp_err;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  dmem_pipe #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .addr       (addr),
    .wdata      (wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mask_mode  (mask_mode),
    .sext       (sext),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_good  (resp_good),
    .resp_err   (resp_err),
    .rdata      (rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    addr      = $urandom;
    wdata     = $urandom;
    mem_read  = 1'($urandom);
    mem_write = 1'($urandom);
    mask_mode = 2'($urandom);
    sext      = 1'($urandom);
  endtask

  // Expected error code, then model load result / memory update.
  task automatic model(input logic rd, input logic wr, input logic [1:0] mm, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input bit upd,
                       output logic [1:0] e_err, output logic [31:0] e_rd);
    logic [31:0] w, mask;
    int sh;
    if (rd == wr || mm == 2'd3) e_err = 2'd3;
    else if ((mm == 2'd1 && a[0]) || (mm == 2'd2 && a[1:0] != 2'd0)) e_err = 2'd1;
    else if ((a >> 2) >= 32'd256) e_err = 2'd2;
    else e_err = 2'd0;
    e_rd = 32'd0;
    if (e_err == 2'd0) begin
      w    = ref_mem[a[9:2]];
      sh   = 8 * int'(a[1:0]);
      mask = (mm == 2'd0) ? 32'h0000_00FF : (mm == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      if (rd) begin
        e_rd = (w >> sh) & mask;
        if (sx && mm == 2'd0 && e_rd >= 32'd128) e_rd = e_rd + 32'hFFFF_FF00;
        if (sx && mm == 2'd1 && e_rd >= 32'd32768) e_rd = e_rd + 32'hFFFF_0000;
      end else if (upd) begin
        ref_mem[a[9:2]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [1:0] mm, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    int n;
    model(rd, wr, mm, sx, a, wd, 1'b1, e_err, e_rd);
    @(negedge clk);
    req_valid = 1'b1; addr = a; wdata = wd; mem_read = rd; mem_write = wr;
    mask_mode = mm; sext = sx;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    check("latency", 32'(n), 32'(LAT));
    check("resp_good", 32'(resp_good), 32'(e_err == 2'd0));
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("rdata", rdata, e_rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_err", 32'(resp_err), 32'(e_err));
      check("hold_rdata", rdata, e_rd);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  mm;
    logic        rd, wr;
    logic [31:0] a;
    int r;
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_good", 32'(resp_good), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b1;

    // Fill the low 16 words so every later load reads defined data.
    for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 0);

    // Word store then sign-extended byte load of the top byte.
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    // Upper half store, zero-extended half load, full word view.
    do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 0);
    do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    // Misaligned half, out-of-range store (index aliases word 0), word 0 unchanged.
    do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0);
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A5_A5A5, 0);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);
    // Illegal command outranks misalignment.
    do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h3, 32'h0, 0);
    // Backpressure for five cycles.
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

    // Reset during WAIT of a store: store must be dropped.
    @(negedge clk);
    req_valid = 1'b1; addr = 32'h8; wdata = 32'h1234_5678;
    mem_read = 1'b0; mem_write = 1'b1; mask_mode = 2'd2; sext = 1'b0;
    check("rst_test_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_idle_valid", 32'(resp_valid), 32'd0);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0);

    // Randomized mix, mostly legal, some errors and out-of-range.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      rd = (r >= 5); wr = (r >= 1 && r < 5);
      if (r == 9) begin rd = 1'b1; wr = 1'b1; end
      r = $urandom_range(0, 9);
      mm = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = ($urandom_range(0, 19) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                      : 32'($urandom_range(0, 63));
      do_req(rd, wr, mm, 1'($urandom), a, $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 SHALL provide parameter DEPTH, default 256, data memory size in 32-bit words (power of two, 16..4096).
REQ-002 SHALL provide parameter LATENCY, default 2, cycles from request accept to response valid (1..8).
REQ-003 SHALL provide port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port req_valid  input  1  request present.
REQ-006 SHALL provide port req_ready  output  1  block can accept a request.
REQ-007 SHALL provide port addr  input  32  byte address.
REQ-008 SHALL provide port wdata  input  32  store data, right-aligned.
REQ-009 SHALL provide port mem_read  input  1  load request.
REQ-010 SHALL provide port mem_write  input  1  store request.
REQ-011 SHALL provide port mask_mode  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-012 SHALL provide port sext  input  1  sign-extend a byte or half load.
REQ-013 SHALL provide port resp_valid  output  1  response present.
REQ-014 SHALL provide port resp_ready  input  1  consumer accepts the response.
REQ-015 SHALL provide port resp_good  output  1  request completed without error.
REQ-016 SHALL provide port resp_err  output  2  error code: 00 none, 01 misaligned, 10 out-of-range, 11 illegal command.
REQ-017 SHALL provide port rdata  output  32  load result, zero on stores and errors.

Function
REQ-018 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, with one outstanding request at a time.
REQ-019 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-020 SHALL latch addr, wdata, mem_read, mem_write, mask_mode and sext on accept; later input changes SHALL have no effect on the transaction.
REQ-021 SHALL load a down-counter with LATENCY-1 on accept; WAIT decrements it and moves to RESP at zero; when LATENCY=1 the FSM goes straight from IDLE to RESP.
REQ-022 SHALL assert resp_valid exactly LATENCY cycles after the accept edge, and hold resp_valid, resp_good, resp_err and rdata stable until the edge with resp_ready=1, then return to IDLE.
REQ-023 SHALL classify errors at accept in this priority: illegal (mem_read & mem_write, neither set, or mask_mode=11), then misaligned (half with addr[0]=1, or word with addr[1:0]!=00), then out-of-range (addr[31:2] >= DEPTH).
REQ-024 SHALL commit a store on the WAIT->RESP (or IDLE->RESP) edge, touching only the addressed byte lanes: byte lane addr[1:0], half lane addr[1], or the full word.
REQ-025 SHALL NOT modify memory for an erroring store.
REQ-026 SHALL extract the addressed byte or half for loads, zero-extend it when sext=0 and sign-extend it when sext=1; sext SHALL be ignored for word loads.
REQ-027 SHALL sample load data on entry to RESP, so a load always observes every previously completed store.
REQ-028 SHALL set resp_good=!error and rdata=0 when the request is a store or has any error.

Reset
REQ-029 SHALL, while reset=0 on a clock edge, force IDLE with counter 0, req_ready=0 during reset then 1, resp_valid=0, resp_good=0, resp_err=00, rdata=0.
REQ-030 SHALL abandon an in-flight request on reset, including a store not yet committed; memory contents SHALL NOT be cleared.

Structure
REQ-031 SHALL place the mask_mode encodings, the resp_err codes and the FSM state encoding in a shared package, dmem_pkg.
REQ-032 SHALL use one sub-module, dmem_lane_align, which is combinational and performs load extraction/extension and store byte-enable/data-shift generation.

Verification
REQ-033 SHALL cover: LATENCY=2, word store 0xDEADBEEF at 0x10, then byte load with sext=1 at 0x13 -> resp_valid 2 cycles after each accept, rdata=0xFFFFFFDE, resp_good=1.
REQ-034 SHALL cover: half store 0x8001 at 0x22, then half load with sext=0 at 0x22 -> rdata=0x00008001; word at 0x20 shows the lower half unchanged.
REQ-035 SHALL cover: half load at 0x21 -> resp_err=01, resp_good=0, rdata=0; word store at 0x400 with DEPTH=256 -> resp_err=10 and memory unchanged.
REQ-036 SHALL cover: mem_read=mem_write=1 with addr 0x3 -> resp_err=11, which takes priority over misaligned.
REQ-037 SHALL cover: resp_ready held 0 for 5 cycles -> outputs stable and req_ready=0 throughout; accept occurs on the cycle after the resp_ready handshake.
REQ-038 SHALL cover: reset=0 asserted in WAIT of a store of 0x12345678 to 0x8 -> next load of 0x8 returns the prior value.
